// File: rtl/switch_key_reader_if.sv
// Bridge-side register bus for the switch/key input peripheral.
// The bridge drives strobe/address/data; the peripheral returns combinational read data.
interface switch_key_reader_if;
    logic        SK_En;
    logic [31:0] SK_Addr;
    logic [31:0] SK_Data;
    logic [31:0] SK_Out;

    modport master (output SK_En, output SK_Addr, output SK_Data, input SK_Out);
    modport slave  (input SK_En, input SK_Addr, input SK_Data, output SK_Out);
endinterface

// File: rtl/switch_key_reader.sv
// Synchronises and debounces 32 DIP switches and 8 keys, latches press/change events, raises a level IRQ.
// Reads are combinational on the address; writes land on the strobe edge; no backpressure on the bridge.
module switch_key_reader #(
    parameter logic [31:0] DB_MAX = 32'h1000
) (
    input  logic                       clk,
    input  logic                       reset,
    switch_key_reader_if.slave         bus,
    input  logic [31:0]                dip_switch,
    input  logic [7:0]                 user_key,
    output logic                       SK_IRQ
);
    localparam int NB = 40;

    // Bits [31:0] are switches, [39:32] are keys; pins are active-low.
    logic [NB-1:0] pin_on;
    logic [NB-1:0] sync1_q, sync2_q, samp_q, stable_q, stable_prev_q;
    logic [NB-1:0] stable_d, agree;
    logic [31:0]   cnt_q, cnt_d;
    logic          tick;
    logic [8:0]    event_q, event_d, ev_set, ev_clr;
    logic [8:0]    irq_en_q;
    logic          irq_q;
    logic [31:0]   word_addr;
    logic          wr_event, wr_irq_en;
    logic [31:0]   rd_dat;
    logic          unused_bus_bits;

    assign pin_on          = ~{user_key, dip_switch};
    assign word_addr       = {bus.SK_Addr[31:2], 2'b00};
    assign unused_bus_bits = ^{bus.SK_Addr[1:0], bus.SK_Data[31:9]};
    assign wr_event        = bus.SK_En && (word_addr == 32'h0000_7f48);
    assign wr_irq_en       = bus.SK_En && (word_addr == 32'h0000_7f4c);

    assign tick  = (cnt_q == DB_MAX - 32'd1);
    assign cnt_d = tick ? 32'd0 : cnt_q + 32'd1;

    // A bit is accepted only when two consecutive tick samples agree.
    assign agree    = ~(sync2_q ^ samp_q);
    assign stable_d = tick ? ((sync2_q & agree) | (stable_q & ~agree)) : stable_q;

    always_comb begin
        ev_set[7:0] = stable_q[39:32] & ~stable_prev_q[39:32];
        ev_set[8]   = |(stable_q[31:0] ^ stable_prev_q[31:0]);
        ev_clr      = wr_event ? bus.SK_Data[8:0] : 9'd0;
        // Set after clear so a same-edge event survives a write-1-to-clear.
        event_d     = (event_q & ~ev_clr) | ev_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            samp_q        <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            event_q       <= '0;
            irq_en_q      <= '0;
            irq_q         <= 1'b0;
        end else begin
            sync1_q       <= pin_on;
            sync2_q       <= sync1_q;
            cnt_q         <= cnt_d;
            if (tick) begin
                samp_q <= sync2_q;
            end
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            event_q       <= event_d;
            if (wr_irq_en) begin
                irq_en_q <= bus.SK_Data[8:0];
            end
            irq_q         <= |(event_q & irq_en_q);
        end
    end

    always_comb begin
        rd_dat = 32'd0;
        case (word_addr)
            32'h0000_7f40: rd_dat = stable_q[31:0];
            32'h0000_7f44: rd_dat = {24'd0, stable_q[39:32]};
            32'h0000_7f48: rd_dat = {23'd0, event_q};
            32'h0000_7f4c: rd_dat = {23'd0, irq_en_q};
            default:       rd_dat = 32'd0;
        endcase
    end

    assign bus.SK_Out = rd_dat;
    assign SK_IRQ     = irq_q;
endmodule

// File: tb/tb_switch_key_reader.sv
// Bench for switch_key_reader with DB_MAX=4: directed scenarios plus randomized pin/bus traffic
// compared against a rule-level model of sampling, acceptance, event latching and IRQ.
module tb_switch_key_reader;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dip_switch;
    logic [7:0]  user_key;
    logic        sk_irq;

    int errors = 0;
    int checks = 0;

    switch_key_reader_if sk_bus ();

    switch_key_reader #(.DB_MAX(32'd4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (sk_bus),
        .dip_switch (dip_switch),
        .user_key   (user_key),
        .SK_IRQ     (sk_irq)
    );

    always #5 clk = ~clk;

    // Model state: inputs seen at the last two edges, last tick sample, accepted levels, events.
    logic [39:0] hist[$];
    logic [39:0] m_samp, m_stable, m_prev;
    logic [8:0]  m_event, m_irq_en;
    logic        m_irq;
    int          m_k;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h7f40: return m_stable[31:0];
            32'h7f44: return {24'd0, m_stable[39:32]};
            32'h7f48: return {23'd0, m_event};
            32'h7f4c: return {23'd0, m_irq_en};
            default:  return 32'd0;
        endcase
    endfunction

    task automatic cycle();
        logic [39:0] vin, s2, nst;
        logic [8:0]  set, nev;
        logic        nirq;
        logic [31:0] w;
        @(posedge clk);
        if (reset) begin
            hist.delete();
            hist.push_back(40'd0);
            hist.push_back(40'd0);
            m_samp = '0; m_stable = '0; m_prev = '0;
            m_event = '0; m_irq_en = '0; m_irq = 1'b0; m_k = 0;
        end else begin
            vin = ~{user_key, dip_switch};
            s2  = hist[0];
            nst = m_stable;
            if ((m_k % DB) == DB - 1) begin
                for (int i = 0; i < 40; i++)
                    if (s2[i] == m_samp[i]) nst[i] = s2[i];
                m_samp = s2;
            end
            set[7:0] = m_stable[39:32] & ~m_prev[39:32];
            set[8]   = (m_stable[31:0] != m_prev[31:0]);
            nirq     = |(m_event & m_irq_en);
            w        = {sk_bus.SK_Addr[31:2], 2'b00};
            nev      = m_event;
            if (sk_bus.SK_En && w == 32'h7f48) nev = nev & ~sk_bus.SK_Data[8:0];
            nev = nev | set;
            if (sk_bus.SK_En && w == 32'h7f4c) m_irq_en = sk_bus.SK_Data[8:0];
            m_prev   = m_stable;
            m_stable = nst;
            m_event  = nev;
            m_irq    = nirq;
            m_k++;
            void'(hist.pop_front());
            hist.push_back(vin);
        end
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        sk_bus.SK_En = 1'b1; sk_bus.SK_Addr = a; sk_bus.SK_Data = d;
        cycle();
        sk_bus.SK_En = 1'b0; sk_bus.SK_Data = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        addrs = '{32'h7f40, 32'h7f44, 32'h7f48, 32'h7f4c};
        dip_switch = '1; user_key = '1; reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sk_bus.SK_Addr = addrs[i]; #1;
            checks++;
            if (sk_bus.SK_Out !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h want=00000000", addrs[i], sk_bus.SK_Out);
            end
        end
        checks++;
        if (sk_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", sk_irq); end
        do_write(32'h7f4c, 32'h1ff);
        sk_bus.SK_Addr = 32'h7f4c; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h1ff) begin
            errors++; $display("FAIL irq_en_readback got=%h want=000001ff", sk_bus.SK_Out);
        end
        cycle();
        checks++;
        if (sk_irq !== 1'b0) begin errors++; $display("FAIL irq_en_only_irq got=%b want=0", sk_irq); end
    endtask

    task automatic test_key_irq();
        int first = -1;
        do_write(32'h7f4c, 32'h001);
        user_key[0] = 1'b0;
        sk_bus.SK_Addr = 32'h7f44;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            checks++;
            if (sk_bus.SK_Out !== m_read(32'h7f44) || sk_irq !== m_irq) begin
                errors++;
                $display("FAIL key_track cyc=%0d got=%h/%b want=%h/%b", c, sk_bus.SK_Out, sk_irq, m_read(32'h7f44), m_irq);
            end
            if (first < 0 && sk_bus.SK_Out == 32'h01) first = c;
        end
        checks++;
        if (first < 1 || first > 2 + 2 * DB) begin
            errors++; $display("FAIL key_latency got=%0d want<=%0d", first, 2 + 2 * DB);
        end
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h001 || sk_irq !== 1'b1) begin
            errors++; $display("FAIL key_event got=%h irq=%b want=00000001 irq=1", sk_bus.SK_Out, sk_irq);
        end
        do_write(32'h7f48, 32'h001);
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'd0) begin errors++; $display("FAIL w1c_event got=%h want=0", sk_bus.SK_Out); end
        cycle();
        checks++;
        if (sk_irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b want=0", sk_irq); end
        user_key[0] = 1'b1;
        cycles(20);
        checks++;
        if (sk_bus.SK_Out !== 32'd0 || sk_irq !== 1'b0) begin
            errors++; $display("FAIL release_event got=%h irq=%b want=0 irq=0", sk_bus.SK_Out, sk_irq);
        end
    endtask

    task automatic test_glitch();
        dip_switch[5] = 1'b0;
        cycles(2);
        dip_switch[5] = 1'b1;
        sk_bus.SK_Addr = 32'h7f40;
        for (int c = 0; c < 20; c++) begin
            cycle();
            checks++;
            if (sk_bus.SK_Out !== 32'd0) begin
                errors++; $display("FAIL glitch_sw cyc=%0d got=%h want=0", c, sk_bus.SK_Out);
            end
        end
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'd0) begin errors++; $display("FAIL glitch_event got=%h want=0", sk_bus.SK_Out); end
        dip_switch[5] = 1'b0;
        cycles(12);
        sk_bus.SK_Addr = 32'h7f40; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h20) begin errors++; $display("FAIL hold_sw got=%h want=00000020", sk_bus.SK_Out); end
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h100) begin errors++; $display("FAIL hold_event got=%h want=00000100", sk_bus.SK_Out); end
    endtask

    task automatic test_collision();
        bit found = 0;
        do_write(32'h7f48, 32'h100);
        dip_switch[5] = 1'b1;
        for (int c = 0; c < 30 && !found; c++) begin
            if (m_stable[31:0] != m_prev[31:0]) begin
                do_write(32'h7f48, 32'h100);
                found = 1;
            end else begin
                cycle();
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL collision_timeout got=none want=set edge within 30"); end
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h100) begin
            errors++; $display("FAIL collision_event got=%h want=00000100", sk_bus.SK_Out);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] exp48, exp4c;
        user_key[3] = 1'b0;
        cycles(14);
        exp48 = m_read(32'h7f48);
        exp4c = m_read(32'h7f4c);
        do_write(32'h7f50, 32'hffff_ffff);
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== exp48) begin errors++; $display("FAIL unmapped_ev got=%h want=%h", sk_bus.SK_Out, exp48); end
        sk_bus.SK_Addr = 32'h7f4c; #1;
        checks++;
        if (sk_bus.SK_Out !== exp4c) begin errors++; $display("FAIL unmapped_en got=%h want=%h", sk_bus.SK_Out, exp4c); end
        sk_bus.SK_Addr = 32'h7f50; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'd0) begin errors++; $display("FAIL unmapped_rd got=%h want=0", sk_bus.SK_Out); end
        sk_bus.SK_Addr = 32'h7f46; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h08) begin errors++; $display("FAIL align_rd got=%h want=00000008", sk_bus.SK_Out); end
    endtask

    task automatic test_random();
        logic [31:0] tab [6];
        logic [31:0] a;
        int b;
        tab = '{32'h7f40, 32'h7f44, 32'h7f48, 32'h7f4c, 32'h7f50, 32'h7f3c};
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 39);
                if (b < 32) dip_switch[b] = ~dip_switch[b];
                else        user_key[b - 32] = ~user_key[b - 32];
            end
            a = tab[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 6) == 0) begin
                do_write(a, $urandom);
            end else begin
                sk_bus.SK_Addr = a;
                cycle();
            end
            a = tab[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            sk_bus.SK_Addr = a; #1;
            checks++;
            if (sk_bus.SK_Out !== m_read(a) || sk_irq !== m_irq) begin
                errors++;
                $display("FAIL random cyc=%0d addr=%h got=%h/%b want=%h/%b", c, a, sk_bus.SK_Out, sk_irq, m_read(a), m_irq);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] addrs [4];
        addrs = '{32'h7f40, 32'h7f44, 32'h7f48, 32'h7f4c};
        dip_switch = '1; user_key = '1;
        cycles(15);
        do_write(32'h7f4c, 32'h1ff);
        do_write(32'h7f48, 32'h1ff);
        user_key[0] = 1'b0; dip_switch[7] = 1'b0;
        cycles(15);
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h101 || sk_irq !== 1'b1) begin
            errors++; $display("FAIL pre_reset got=%h irq=%b want=00000101 irq=1", sk_bus.SK_Out, sk_irq);
        end
        dip_switch[20] = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sk_bus.SK_Addr = addrs[i]; #1;
            checks++;
            if (sk_bus.SK_Out !== 32'd0) begin
                errors++; $display("FAIL midrst_read addr=%h got=%h want=0", addrs[i], sk_bus.SK_Out);
            end
        end
        checks++;
        if (sk_irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got=%b want=0", sk_irq); end
        sk_bus.SK_Addr = 32'h7f44;
        cycles(6);
        checks++;
        if (sk_bus.SK_Out !== 32'd0) begin errors++; $display("FAIL midrst_early got=%h want=0", sk_bus.SK_Out); end
        cycles(8);
        checks++;
        if (sk_bus.SK_Out !== 32'h01) begin errors++; $display("FAIL reacq_key got=%h want=00000001", sk_bus.SK_Out); end
        sk_bus.SK_Addr = 32'h7f40; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h0010_0080) begin
            errors++; $display("FAIL reacq_sw got=%h want=00100080", sk_bus.SK_Out);
        end
        sk_bus.SK_Addr = 32'h7f48; #1;
        checks++;
        if (sk_bus.SK_Out !== 32'h101 || sk_irq !== 1'b0) begin
            errors++; $display("FAIL reacq_event got=%h irq=%b want=00000101 irq=0", sk_bus.SK_Out, sk_irq);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dip_switch = '1;
        user_key = '1;
        sk_bus.SK_En = 1'b0;
        sk_bus.SK_Addr = 32'd0;
        sk_bus.SK_Data = 32'd0;
        @(negedge clk);
        test_reset();
        test_key_irq();
        test_glitch();
        test_collision();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
